// File: rtl/uart_rx_if.sv
// Host-side signal bundle of the UART receiver: oversample tick, serial line, byte buffer and error flags.
// The master drives enable/Rx/rd_ack; the slave (receiver) drives the byte buffer, error flags and rx_busy.
interface uart_rx_if;
  logic       enable;
  logic       Rx;
  logic       rd_ack;
  logic [7:0] d_out;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       rx_busy;

  modport master (
    output enable, Rx, rd_ack,
    input  d_out, rx_valid, parity_err, frame_err, overrun_err, rx_busy
  );

  modport slave (
    input  enable, Rx, rd_ack,
    output d_out, rx_valid, parity_err, frame_err, overrun_err, rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver for start + 8 data bits (MSB first) + even parity + stop, SAMPLE enable ticks per bit.
// Handshake: rx_valid rises on commit and holds until an rd_ack seen while rx_valid=1; a commit wins over a coincident rd_ack.
module uart_rx #(
  parameter int SAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_rx_if.slave   bus,
  output logic [2:0] state_dbg_o
);
  localparam int TW = $clog2(SAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(SAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          sync_q, rx_s_q;
  logic          commit;
  logic [7:0]    dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= bus.Rx;
      rx_s_q  <= sync_q;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Frame FSM: every sample point clears tick_q, so the counter never wraps.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    commit  = 1'b0;
    if (bus.enable) begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            tick_d  = '0;
            state_d = START;
          end
        end
        START: begin
          if (tick_q == TICK_MID) begin
            if (rx_s_q) begin
              state_d = IDLE;
            end else begin
              tick_d  = '0;
              bit_d   = '0;
              state_d = DATA;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        DATA: begin
          if (tick_q == TICK_LAST) begin
            shift_d = {shift_q[6:0], rx_s_q};
            tick_d  = '0;
            if (bit_q == 3'd7) state_d = PARITY;
            else               bit_d   = bit_q + 3'd1;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        PARITY: begin
          if (tick_q == TICK_LAST) begin
            par_d   = rx_s_q;
            tick_d  = '0;
            state_d = STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        STOP: begin
          if (tick_q == TICK_LAST) begin
            commit  = 1'b1;
            tick_d  = '0;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Byte buffer: the stop bit is the live synchronized sample at commit time.
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (commit) begin
      dout_d  = shift_q;
      perr_d  = (^shift_q) ^ par_q;
      ferr_d  = ~rx_s_q;
      valid_d = 1'b1;
      if (valid_q && !bus.rd_ack) ovr_d = 1'b1;
    end else if (bus.rd_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  assign bus.d_out       = dout_q;
  assign bus.rx_valid    = valid_q;
  assign bus.parity_err  = perr_q;
  assign bus.frame_err   = ferr_q;
  assign bus.overrun_err = ovr_q;
  assign bus.rx_busy     = (state_q != IDLE);
  assign state_dbg_o     = state_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus randomized frames, scored against a frame-level buffer model.
module tb_uart_rx;
  localparam int SAMPLE = 16;

  logic       clk;
  logic       rst_n;
  logic [2:0] state_dbg;

  uart_rx_if bus();

  uart_rx #(.SAMPLE(SAMPLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .state_dbg_o(state_dbg)
  );

  // clock / reset / enable generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int en_period = 1;
  int en_cnt    = 0;
  initial begin
    bus.enable = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      en_cnt     = (en_cnt + 1) % en_period;
      bus.enable = (en_cnt == 0);
    end
  end

  // scoreboard and model
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        m_valid  = 1'b0;
  logic        m_ovr    = 1'b0;
  logic [7:0]  m_dout   = 8'h00;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_commit(input logic [7:0] data, input logic pbit, input logic stop,
                              input logic ack_now);
    logic perr, ferr;
    perr = ($countones({data, pbit}) % 2) != 0;
    ferr = (stop == 1'b0);
    if (m_valid && !ack_now) m_ovr = 1'b1;
    m_valid = 1'b1;
    m_dout  = data;
    exp_q.push_back({m_ovr, m_valid, ferr, perr, data});
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_dout  = 8'h00;
    exp_q.delete();
  endtask

  task automatic check_frame(input string tag);
    logic [11:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s_sb: got empty queue expected an entry", tag);
      return;
    end
    n_pass++;
    e = exp_q.pop_front();
    check({tag, "_d_out"},    32'(bus.d_out),       32'(e[7:0]));
    check({tag, "_perr"},     32'(bus.parity_err),  32'(e[8]));
    check({tag, "_ferr"},     32'(bus.frame_err),   32'(e[9]));
    check({tag, "_valid"},    32'(bus.rx_valid),    32'(e[10]));
    check({tag, "_overrun"},  32'(bus.overrun_err), 32'(e[11]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d_out"},   32'(bus.d_out),       32'h0);
    check({tag, "_valid"},   32'(bus.rx_valid),    32'h0);
    check({tag, "_perr"},    32'(bus.parity_err),  32'h0);
    check({tag, "_ferr"},    32'(bus.frame_err),   32'h0);
    check({tag, "_overrun"}, 32'(bus.overrun_err), 32'h0);
    check({tag, "_busy"},    32'(bus.rx_busy),     32'h0);
  endtask

  // driver tasks
  task automatic send_frame(input logic [7:0] data, input logic pbit, input logic stop);
    logic [10:0] bits;
    bits = {1'b0, data, pbit, stop};
    @(posedge clk);
    #1;
    for (int i = 10; i >= 0; i--) begin
      bus.Rx = bits[i];
      repeat (SAMPLE * en_period) @(posedge clk);
      #1;
    end
    bus.Rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    bus.Rx = 1'b1;
    repeat (n * SAMPLE * en_period) @(posedge clk);
    #1;
  endtask

  task automatic host_ack(input string tag);
    @(posedge clk);
    #1;
    bus.rd_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.rd_ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    check({tag, "_valid"},   32'(bus.rx_valid),    32'(m_valid));
    check({tag, "_overrun"}, 32'(bus.overrun_err), 32'(m_ovr));
  endtask

  task automatic reset_mid_frame(input logic [7:0] data, input string tag);
    int bitc;
    bitc = SAMPLE * en_period;
    @(posedge clk);
    #1;
    bus.Rx = 1'b0;
    repeat (bitc) @(posedge clk);
    #1;
    for (int i = 7; i >= 4; i--) begin
      bus.Rx = data[i];
      repeat (bitc) @(posedge clk);
      #1;
    end
    bus.Rx = data[3];
    repeat (bitc / 2) @(posedge clk);
    #1;
    check({tag, "_busy_before"}, 32'(bus.rx_busy), 32'h1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs(tag);
    bus.Rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_bits(2);
  endtask

  // main sequence
  logic [7:0] rd;
  logic       rp, rs;

  initial begin
    rst_n      = 1'b0;
    bus.Rx     = 1'b1;
    bus.rd_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("rst_state_idle", 32'(state_dbg), 32'h0);
    rst_n = 1'b1;
    idle_bits(1);

    send_frame(8'hA5, 1'b0, 1'b1);
    model_commit(8'hA5, 1'b0, 1'b1, 1'b0);
    check_frame("good_a5");
    host_ack("good_ack");

    send_frame(8'h3C, 1'b1, 1'b1);
    model_commit(8'h3C, 1'b1, 1'b1, 1'b0);
    check_frame("perr_3c");
    host_ack("perr_ack");

    send_frame(8'h81, 1'b0, 1'b0);
    model_commit(8'h81, 1'b0, 1'b0, 1'b0);
    check_frame("ferr_81");
    idle_bits(2);
    host_ack("ferr_ack");

    @(posedge clk);
    #1;
    bus.Rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.Rx = 1'b1;
    check("glitch_busy_on", 32'(bus.rx_busy), 32'h1);
    repeat (10) @(posedge clk);
    #1;
    check("glitch_busy_off", 32'(bus.rx_busy), 32'h0);
    repeat (200) @(posedge clk);
    #1;
    check("glitch_valid", 32'(bus.rx_valid), 32'(m_valid));
    check("glitch_d_out", 32'(bus.d_out), 32'(m_dout));

    send_frame(8'h11, 1'b0, 1'b1);
    model_commit(8'h11, 1'b0, 1'b1, 1'b0);
    check_frame("ovr_11");
    send_frame(8'h22, 1'b0, 1'b1);
    model_commit(8'h22, 1'b0, 1'b1, 1'b0);
    check_frame("ovr_22");
    host_ack("ovr_ack");
    host_ack("idle_ack");

    send_frame(8'h11, 1'b0, 1'b1);
    model_commit(8'h11, 1'b0, 1'b1, 1'b0);
    check_frame("sim_11");
    fork
      send_frame(8'h22, 1'b0, 1'b1);
      begin
        @(posedge clk);
        repeat (SAMPLE / 2 + 10 * SAMPLE + 2) @(posedge clk);
        #1;
        bus.rd_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_ack = 1'b0;
      end
    join
    model_commit(8'h22, 1'b0, 1'b1, 1'b1);
    check_frame("sim_22");

    reset_mid_frame(8'h5A, "rmf1");
    send_frame(8'h5A, 1'b0, 1'b1);
    model_commit(8'h5A, 1'b0, 1'b1, 1'b0);
    check_frame("rmf1_5a");

    en_period = 3;
    reset_mid_frame(8'h5A, "rmf3");
    send_frame(8'h5A, 1'b0, 1'b1);
    model_commit(8'h5A, 1'b0, 1'b1, 1'b0);
    check_frame("rmf3_5a");
    idle_bits(1);

    for (int n = 0; n < 20; n++) begin
      en_period = $urandom_range(1, 3);
      idle_bits(1);
      rd = 8'($urandom_range(0, 255));
      rp = (^rd) ^ ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 1) == 1) host_ack("rnd_ack");
      send_frame(rd, rp, rs);
      model_commit(rd, rp, rs, 1'b0);
      check_frame("rnd");
      if (!rs) idle_bits(2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
